// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, reads the imem combinationally, queues {pc, word} for decode.
// One cycle fetch-to-valid; stalls the PC when the queue is full and decode holds instr_ready low.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rd,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  misalign_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  misalign_q, misalign_d;
    logic [DATA_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] word_mem_q [FIFO_DEPTH];

    logic fifo_full;
    logic push;
    logic pop;

    assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
    // A redirect voids the handshake so decode never consumes a wrong-path word.
    assign instr_valid  = (count_q != '0) & ~redirect_valid;
    assign pop          = instr_valid & instr_ready;
    assign push         = fetch_en & ~redirect_valid & (~fifo_full | pop);

    assign imem_addr    = fetch_pc_q;
    assign instr        = word_mem_q[rd_ptr_q];
    assign instr_pc     = pc_mem_q[rd_ptr_q];
    assign misalign_err = misalign_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                word_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
                word_mem_q[wr_ptr_q] <= imem_rd;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, checked against a queue model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_err;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction
    assign imem_rd = rom(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_mis;
    int          npass = 0;
    int          ntot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle from the negedge, check outputs, then advance the model at the posedge.
    task automatic cyc(input logic rs, input logic en, input logic rdy,
                       input logic rv, input logic [31:0] rp);
        logic exp_vld;
        logic do_pop;
        logic do_push;
        rst_n          = rs;
        fetch_en       = en;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        exp_vld = (mq.size() != 0) && !rv;
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_vld});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        if (exp_vld) begin
            chk("instr_pc", instr_pc, mq[0].pc);
            chk("instr", instr, mq[0].word);
        end
        @(posedge clk);
        do_pop  = exp_vld && rdy;
        do_push = en && !rv && ((mq.size() < DEPTH) || do_pop);
        if (!rs) begin
            mq.delete();
            m_pc  = RST_PC;
            m_mis = 1'b0;
        end else if (rv) begin
            mq.delete();
            m_pc  = {rp[31:2], 2'b00};
            m_mis = m_mis | (rp[1:0] != 2'b00);
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: m_pc, word: rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        m_pc = RST_PC; m_mis = 1'b0;
        @(negedge clk);

        // Reset state, then streaming with decode always ready.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0103);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Decode stalled from reset: queue fills, PC parks at base+0x10, then drains.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_addr_stuck", imem_addr, 32'h0040_0010);
        chk("full_head_pc", instr_pc, 32'h0040_0000);
        // Full queue with simultaneous pop and push.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Mid-stream aligned redirect, then misaligned redirect.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0040);
        chk("redir_addr", imem_addr, 32'h0040_0040);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0042);
        chk("misalign_set", {31'd0, misalign_err}, 32'd1);
        chk("misalign_addr", imem_addr, 32'h0040_0040);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, i > 2, 1'b0, 32'h0);

        // Hold with a half-full queue, toggling fetch_en, then reset.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0200);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst6_addr", imem_addr, 32'h0040_0000);
        chk("rst6_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst6_mis", {31'd0, misalign_err}, 32'd0);
        chk("rst6_instr", instr, 32'h0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 200) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                ($urandom % 20) == 0, 32'h0040_0000 + 32'($urandom_range(0, 1023)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
